paddle_bbox_tracker: RTL and testbench
======================================

# paddle_bbox_tracker

Per-frame paddle localizer that consumes the 1-bit merged edge/colour mask stream produced by the edge/colour mask merge stage and reduces each frame to a bounding box, centre point and pixel count. A small FSM debounces detections across frames (search / locked / coast) so the downstream game logic receives a stable `box_valid` even when single frames drop the paddle.

## Interface
- `WIDTH`, 640: active pixels per line
- `HEIGHT`, 480: active lines per frame
- `X_W`, 10: column width, ≥ $clog2(WIDTH)
- `Y_W`, 9: row width, ≥ $clog2(HEIGHT)
- `CNT_W`, 19: pixel-count width, ≥ $clog2(WIDTH*HEIGHT+1)
- `MIN_PIXELS`, 64: minimum mask pixels for a frame to count as a detection
- `MISS_LIMIT`, 3: consecutive missed frames tolerated in COAST before returning to SEARCH

- `clk`, in, 1: clock
- `reset_n`, in, 1: reset, synchronous, active-low
- `pix_valid`, in, 1: merge-stage output valid; one raster pixel per asserted cycle
- `pix_mask`, in, 1: merged mask bit; ignored when `pix_valid`=0
- `frame_done`, out, 1: one-cycle pulse; results for the frame just completed
- `box_valid`, out, 1: box outputs describe a tracked paddle
- `x_min` / `x_max`, out, X_W: horizontal bounds, inclusive
- `y_min` / `y_max`, out, Y_W: vertical bounds, inclusive
- `x_center`, out, X_W: (x_min+x_max)>>1
- `y_center`, out, Y_W: (y_min+y_max)>>1
- `pix_count`, out, CNT_W: mask pixel count of the last completed frame
- `track_state`, out, 2: 0=SEARCH, 1=LOCKED, 2=COAST

## Operation
- Internal raster counters `col`/`row` advance only on `pix_valid`. `col` wraps WIDTH-1→0 and increments `row`. `row` wraps HEIGHT-1→0.
- Accumulators: `acc_xmin`/`acc_ymin` init all-ones, `acc_xmax`/`acc_ymax` init 0, `acc_cnt` init 0.
- On each `pix_valid && pix_mask`: update min/max with the current col/row, increment `acc_cnt`.
- End of frame is `pix_valid` at col=WIDTH-1, row=HEIGHT-1. In that cycle, the final values, including this pixel's contribution, are latched as the frame result. Accumulators re-initialise for the next frame in the same cycle.
- `detected` = frame count ≥ MIN_PIXELS. A frame with count 0 is never detected, even when MIN_PIXELS=0.
- Centre sums are computed at X_W+1 / Y_W+1 bits, then shifted right by 1 (floor).
- The FSM evaluates only on the end-of-frame event:
  - SEARCH: detected → LOCKED and load box; else stay, box held at 0.
  - LOCKED: detected → stay, reload box, miss_cnt=0. Miss → miss_cnt=1, go to COAST, box held. If MISS_LIMIT=0, go to SEARCH instead.
  - COAST: detected → LOCKED, reload box, miss_cnt=0. Miss → miss_cnt+1; when it reaches MISS_LIMIT go to SEARCH and clear the box, else stay and hold the box.
- `box_valid` = (state ≠ SEARCH). `pix_count` updates every frame regardless of state.

## Timing
- All outputs are registered. `frame_done`, box, `pix_count`, `track_state` and `box_valid` update together in the cycle after the end-of-frame pixel (latency 1).
- A first pixel of the next frame arriving the very next cycle is accepted with no stall. There is no back-pressure.
- Gaps (`pix_valid`=0) of any length within or between frames are transparent.
- Reset values: every output 0, `track_state`=SEARCH, counters 0, accumulators at init, miss_cnt 0.
- Reset mid-frame discards the partial frame; the next valid pixel is treated as (0,0).
- `frame_done` is never asserted during or on the cycle reset is active.

## Structure
- Package `paddle_loc_pkg`:
  - `track_state_t` enum (SEARCH, LOCKED, COAST)
  - default WIDTH/HEIGHT constants shared with the merge stage
- Sub-module `paddle_frame_accum`: raster counters, min/max/count accumulators, end-of-frame strobe and latched frame result.
- The top level holds the FSM, miss counter, detection compare and output registers.

## Test plan
Bench uses WIDTH=8, HEIGHT=6, MIN_PIXELS=4, MISS_LIMIT=2.
- **Basic box:** mask=1 at cols 2–5 of row 3 only. Required after end of frame: `frame_done` pulse 1 cycle later, box (2,5,3,3), centre (3,3), count 4, LOCKED, `box_valid`=1.
- **Below threshold:** 3 mask pixels at (0,0),(7,5),(4,2) from SEARCH. Required: count 3, stays SEARCH, `box_valid`=0, box all 0.
- **Coast and drop:** lock on the basic-box frame, then 2 empty frames. Required: frame 2 → COAST with box held (2,5,3,3). Frame 3 → SEARCH, box 0, `box_valid`=0.
- **Recovery from coast:** lock, 1 empty frame, then a frame with mask at cols 0–7 of row 0. Required: COAST, then LOCKED with box (0,7,0,0), centre (3,0).
- **Gaps and back-to-back:** random `pix_valid` gaps inside a frame, with the next frame starting the cycle after the last pixel. Required: results identical to the gap-free run; second frame unaffected by the first.
- **Reset mid-frame:** lock, assert `reset_n`=0 for 1 cycle at pixel 20, then feed a full frame. Required: outputs 0 and SEARCH during/after reset; next `frame_done` only after 48 further valid pixels.

Source files
------------

// File: rtl/paddle_loc_pkg.sv
// Shared types and frame geometry for the paddle localisation stages.
package paddle_loc_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    COAST  = 2'd2
  } track_state_t;

  // Frame geometry shared with the edge/colour mask merge stage.
  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

endpackage

// File: rtl/paddle_frame_accum.sv
// Raster position tracking and per-frame bounding-box / pixel-count accumulation.
// Frame result is presented in the end-of-frame cycle, including that pixel's contribution.
module paddle_frame_accum
  import paddle_loc_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int CNT_W  = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_valid,
  input  logic             pix_mask,
  output logic             eof,
  output logic [X_W-1:0]   fr_xmin,
  output logic [X_W-1:0]   fr_xmax,
  output logic [Y_W-1:0]   fr_ymin,
  output logic [Y_W-1:0]   fr_ymax,
  output logic [CNT_W-1:0] fr_cnt
);

  logic [X_W-1:0]   col;
  logic [Y_W-1:0]   row;
  logic [X_W-1:0]   acc_xmin;
  logic [X_W-1:0]   acc_xmax;
  logic [Y_W-1:0]   acc_ymin;
  logic [Y_W-1:0]   acc_ymax;
  logic [CNT_W-1:0] acc_cnt;
  logic             last_col;
  logic             last_row;
  logic             hit;

  assign last_col = (col == X_W'(WIDTH - 1));
  assign last_row = (row == Y_W'(HEIGHT - 1));
  assign hit      = pix_valid && pix_mask;
  assign eof      = pix_valid && last_col && last_row;

  // Accumulator state merged with the current pixel
  always_comb begin
    fr_xmin = acc_xmin;
    fr_xmax = acc_xmax;
    fr_ymin = acc_ymin;
    fr_ymax = acc_ymax;
    fr_cnt  = acc_cnt;
    if (hit) begin
      if (col < acc_xmin) fr_xmin = col;
      if (col > acc_xmax) fr_xmax = col;
      if (row < acc_ymin) fr_ymin = row;
      if (row > acc_ymax) fr_ymax = row;
      fr_cnt = acc_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col      <= '0;
      row      <= '0;
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (pix_valid) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + Y_W'(1);
      end else begin
        col <= col + X_W'(1);
      end
      if (eof) begin
        acc_xmin <= '1;
        acc_xmax <= '0;
        acc_ymin <= '1;
        acc_ymax <= '0;
        acc_cnt  <= '0;
      end else begin
        acc_xmin <= fr_xmin;
        acc_xmax <= fr_xmax;
        acc_ymin <= fr_ymin;
        acc_ymax <= fr_ymax;
        acc_cnt  <= fr_cnt;
      end
    end
  end

endmodule

// File: rtl/paddle_bbox_tracker.sv
// Per-frame paddle bounding box with a search/locked/coast debounce FSM.
// All results update together one cycle after the end-of-frame pixel.
module paddle_bbox_tracker
  import paddle_loc_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int CNT_W      = 19,
  parameter int MIN_PIXELS = 64,
  parameter int MISS_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_valid,
  input  logic             pix_mask,
  output logic             frame_done,
  output logic             box_valid,
  output logic [X_W-1:0]   x_min,
  output logic [X_W-1:0]   x_max,
  output logic [Y_W-1:0]   y_min,
  output logic [Y_W-1:0]   y_max,
  output logic [X_W-1:0]   x_center,
  output logic [Y_W-1:0]   y_center,
  output logic [CNT_W-1:0] pix_count,
  output logic [1:0]       track_state
);

  localparam int MISS_W = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);
  localparam logic [MISS_W:0] MISS_LIM_V = (MISS_W + 1)'(MISS_LIMIT);

  logic             eof;
  logic [X_W-1:0]   fr_xmin;
  logic [X_W-1:0]   fr_xmax;
  logic [Y_W-1:0]   fr_ymin;
  logic [Y_W-1:0]   fr_ymax;
  logic [CNT_W-1:0] fr_cnt;

  paddle_frame_accum #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .CNT_W  (CNT_W)
  ) u_accum (
    .clk       (clk),
    .reset_n   (reset_n),
    .pix_valid (pix_valid),
    .pix_mask  (pix_mask),
    .eof       (eof),
    .fr_xmin   (fr_xmin),
    .fr_xmax   (fr_xmax),
    .fr_ymin   (fr_ymin),
    .fr_ymax   (fr_ymax),
    .fr_cnt    (fr_cnt)
  );

  track_state_t      state;
  track_state_t      state_nxt;
  logic [MISS_W-1:0] miss_cnt;
  logic [MISS_W-1:0] miss_nxt;
  logic [MISS_W:0]   miss_inc;
  logic              detected;
  logic              box_load;
  logic              box_clear;
  logic [X_W:0]      x_sum;
  logic [Y_W:0]      y_sum;

  // An empty frame never counts, even with a zero threshold
  assign detected = (fr_cnt != '0) && (fr_cnt >= CNT_W'(MIN_PIXELS));
  assign miss_inc = {1'b0, miss_cnt} + (MISS_W + 1)'(1);
  assign x_sum    = {1'b0, fr_xmin} + {1'b0, fr_xmax};
  assign y_sum    = {1'b0, fr_ymin} + {1'b0, fr_ymax};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= SEARCH;
      miss_cnt <= '0;
    end else begin
      state    <= state_nxt;
      miss_cnt <= miss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    miss_nxt  = miss_cnt;
    box_load  = 1'b0;
    box_clear = 1'b0;
    if (eof) begin
      case (state)
        SEARCH: begin
          if (detected) begin
            state_nxt = LOCKED;
            box_load  = 1'b1;
          end else begin
            box_clear = 1'b1;
          end
          miss_nxt = '0;
        end
        LOCKED: begin
          if (detected) begin
            box_load = 1'b1;
            miss_nxt = '0;
          end else if (MISS_LIMIT == 0) begin
            state_nxt = SEARCH;
            box_clear = 1'b1;
            miss_nxt  = '0;
          end else begin
            state_nxt = COAST;
            miss_nxt  = MISS_W'(1);
          end
        end
        COAST: begin
          if (detected) begin
            state_nxt = LOCKED;
            box_load  = 1'b1;
            miss_nxt  = '0;
          end else if (miss_inc >= MISS_LIM_V) begin
            state_nxt = SEARCH;
            box_clear = 1'b1;
            miss_nxt  = '0;
          end else begin
            miss_nxt = miss_inc[MISS_W-1:0];
          end
        end
        default: begin
          state_nxt = SEARCH;
          box_clear = 1'b1;
          miss_nxt  = '0;
        end
      endcase
    end
  end

  // Output registers: one cycle after the end-of-frame pixel
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
      pix_count  <= '0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      x_center   <= '0;
      y_center   <= '0;
    end else begin
      frame_done <= eof;
      if (eof) pix_count <= fr_cnt;
      if (box_load) begin
        x_min    <= fr_xmin;
        x_max    <= fr_xmax;
        y_min    <= fr_ymin;
        y_max    <= fr_ymax;
        x_center <= x_sum[X_W:1];
        y_center <= y_sum[Y_W:1];
      end else if (box_clear) begin
        x_min    <= '0;
        x_max    <= '0;
        y_min    <= '0;
        y_max    <= '0;
        x_center <= '0;
        y_center <= '0;
      end
    end
  end

  assign track_state = state;
  assign box_valid   = (state != SEARCH);

endmodule

// File: tb/tb_paddle_bbox_tracker.sv
// Scoreboard bench for paddle_bbox_tracker on an 8x6 frame.
module tb_paddle_bbox_tracker;

  localparam int WIDTH = 8, HEIGHT = 6, X_W = 3, Y_W = 3, CNT_W = 6;
  localparam int MIN_PIXELS = 4, MISS_LIMIT = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             pix_valid;
  logic             pix_mask;
  logic             frame_done;
  logic             box_valid;
  logic [X_W-1:0]   x_min, x_max, x_center;
  logic [Y_W-1:0]   y_min, y_max, y_center;
  logic [CNT_W-1:0] pix_count;
  logic [1:0]       track_state;

  paddle_bbox_tracker #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W),
    .MIN_PIXELS(MIN_PIXELS), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_mask(pix_mask),
    .frame_done(frame_done), .box_valid(box_valid),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .x_center(x_center), .y_center(y_center),
    .pix_count(pix_count), .track_state(track_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int xmin, xmax, ymin, ymax, xc, yc, cnt, st;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic expect_frame(input string name, input int xmin, input int xmax,
                              input int ymin, input int ymax, input int xc,
                              input int yc, input int cnt, input int st);
    exp_t e;
    e.name = name; e.xmin = xmin; e.xmax = xmax; e.ymin = ymin; e.ymax = ymax;
    e.xc = xc; e.yc = yc; e.cnt = cnt; e.st = st;
    exp_q.push_back(e);
  endtask

  // Monitor: every frame_done cycle pops one expectation
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame_done: got 1 expected 0 at time %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".x_min"}, int'(x_min), e.xmin);
        chk({e.name, ".x_max"}, int'(x_max), e.xmax);
        chk({e.name, ".y_min"}, int'(y_min), e.ymin);
        chk({e.name, ".y_max"}, int'(y_max), e.ymax);
        chk({e.name, ".x_center"}, int'(x_center), e.xc);
        chk({e.name, ".y_center"}, int'(y_center), e.yc);
        chk({e.name, ".pix_count"}, int'(pix_count), e.cnt);
        chk({e.name, ".track_state"}, int'(track_state), e.st);
        chk({e.name, ".box_valid"}, int'(box_valid), (e.st != 0) ? 1 : 0);
      end
    end
  end

  // Feed raster pixels [lo, hi) of mask m; optional idle gaps carry mask=1 to prove it is ignored
  task automatic send_pixels(input logic [47:0] m, input bit gaps, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if (gaps && i != lo) begin
        repeat ($urandom_range(0, 2)) begin
          pix_valid = 1'b0;
          pix_mask  = 1'b1;
          @(posedge clk); #1;
        end
      end
      pix_valid = 1'b1;
      pix_mask  = m[i];
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    pix_mask  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, ".frame_done"}, int'(frame_done), 0);
    chk({tag, ".box_valid"}, int'(box_valid), 0);
    chk({tag, ".track_state"}, int'(track_state), 0);
    chk({tag, ".box"}, int'({x_min, x_max, y_min, y_max, x_center, y_center}), 0);
    chk({tag, ".pix_count"}, int'(pix_count), 0);
  endtask

  logic [47:0] m_basic, m_below, m_row0, m_empty;

  initial begin
    m_empty = '0;
    m_basic = '0;
    for (int c = 2; c <= 5; c++) m_basic[3*8 + c] = 1'b1;
    m_below = '0;
    m_below[0]  = 1'b1;
    m_below[47] = 1'b1;
    m_below[20] = 1'b1;
    m_row0 = '0;
    for (int c = 0; c < 8; c++) m_row0[c] = 1'b1;

    reset_n   = 1'b0;
    pix_valid = 1'b0;
    pix_mask  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Basic box, then two empty frames coast and drop
    expect_frame("basic", 2, 5, 3, 3, 3, 3, 4, 1);
    send_pixels(m_basic, 0, 0, 48);
    repeat (2) @(posedge clk); #1;
    expect_frame("coast1", 2, 5, 3, 3, 3, 3, 0, 2);
    send_pixels(m_empty, 0, 0, 48);
    expect_frame("drop", 0, 0, 0, 0, 0, 0, 0, 0);
    send_pixels(m_empty, 0, 0, 48);

    // Below threshold from SEARCH
    expect_frame("below", 0, 0, 0, 0, 0, 0, 3, 0);
    send_pixels(m_below, 0, 0, 48);

    // Recovery from coast
    expect_frame("relock", 2, 5, 3, 3, 3, 3, 4, 1);
    send_pixels(m_basic, 0, 0, 48);
    expect_frame("coast2", 2, 5, 3, 3, 3, 3, 0, 2);
    send_pixels(m_empty, 0, 0, 48);
    expect_frame("recover", 0, 7, 0, 0, 3, 0, 8, 1);
    send_pixels(m_row0, 0, 0, 48);

    // Gapped frames fed back-to-back
    expect_frame("gap_basic", 2, 5, 3, 3, 3, 3, 4, 1);
    send_pixels(m_basic, 1, 0, 48);
    expect_frame("gap_row0", 0, 7, 0, 0, 3, 0, 8, 1);
    send_pixels(m_row0, 1, 0, 48);
    expect_frame("gap_below", 0, 7, 0, 0, 3, 0, 3, 2);
    send_pixels(m_below, 1, 0, 48);
    expect_frame("gap_basic2", 2, 5, 3, 3, 3, 3, 4, 1);
    send_pixels(m_basic, 1, 0, 48);
    repeat (3) @(posedge clk); #1;

    // Reset mid-frame at pixel 20 while LOCKED
    send_pixels(m_basic, 0, 0, 20);
    reset_n   = 1'b0;
    pix_valid = 1'b1;
    pix_mask  = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_mask  = 1'b0;
    check_reset_outputs("mid_reset");
    #1;
    reset_n = 1'b1;
    send_pixels(m_basic, 0, 0, 47);
    repeat (2) @(posedge clk); #1;
    chk("post_reset.track_state", int'(track_state), 0);
    chk("post_reset.box_valid", int'(box_valid), 0);
    expect_frame("after_reset", 2, 5, 3, 3, 3, 3, 4, 1);
    send_pixels(m_basic, 0, 47, 48);

    repeat (5) @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
